gate_truth_checker: RTL and testbench

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

---
 rtl/gate_truth_checker.sv | 117 +++++++++++
 tb/tb_gate_truth_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - exhaustive 2-input gate checker against a truth table (optional GATE_CHECK_MASK_EN)
module gate_truth_checker #(
    parameter logic [3:0] TRUTH  = 4'b0001,
    parameter int         SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       gate_y,
    output logic       drv_a,
    output logic       drv_b,
    output logic       busy,
    output logic       done,
    output logic       all_pass,
    output logic [2:0] pass_cnt,
    output logic [2:0] fail_cnt,
    output logic [3:0] fail_mask
);

    localparam logic [3:0] SETTLE_W = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t     state;
    logic [1:0] vec_idx;
    logic [3:0] settle_cnt;
    logic       match;
    logic       sample;

    // gate_y is only meaningful on the last cycle of each hold window
    assign match  = (gate_y == TRUTH[vec_idx]);
    assign sample = (state == APPLY) && (settle_cnt == SETTLE_W);

    // sequencer: walks vectors 00,01,10,11 and tallies the verdict per vector
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec_idx    <= 2'd0;
            settle_cnt <= 4'd1;
            drv_a      <= 1'b0;
            drv_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            all_pass   <= 1'b0;
            pass_cnt   <= 3'd0;
            fail_cnt   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= APPLY;
                        busy       <= 1'b1;
                        drv_a      <= 1'b0;
                        drv_b      <= 1'b0;
                        vec_idx    <= 2'd0;
                        settle_cnt <= 4'd1;
                        pass_cnt   <= 3'd0;
                        fail_cnt   <= 3'd0;
                        all_pass   <= 1'b0;
                    end
                end
                APPLY: begin
                    if (sample) begin
                        if (match) begin
                            pass_cnt <= pass_cnt + 3'd1;
                        end else begin
                            fail_cnt <= fail_cnt + 3'd1;
                        end
                        settle_cnt <= 4'd1;
                        if (vec_idx == 2'd3) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            drv_a    <= 1'b0;
                            drv_b    <= 1'b0;
                            // include the verdict of this final vector
                            all_pass <= (fail_cnt == 3'd0) && match;
                        end else begin
                            vec_idx        <= vec_idx + 2'd1;
                            {drv_a, drv_b} <= vec_idx + 2'd1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GATE_CHECK_MASK_EN
    logic [3:0] mask_q;

    // per-vector mismatch record, cleared when a new run is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= 4'b0000;
        end else if (state == IDLE && start) begin
            mask_q <= 4'b0000;
        end else if (sample && !match) begin
            mask_q[vec_idx] <= 1'b1;
        end
    end

    assign fail_mask = mask_q;
`else
    assign fail_mask = 4'b0000;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - table-driven bench for gate_truth_checker
module tb_gate_truth_checker;

`ifdef GATE_CHECK_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // SETTLE=2 instance with a selectable gate model
    logic       rst2, start2, gate_y2;
    logic       drv_a2, drv_b2, busy2, done2, all_pass2;
    logic [2:0] pass_cnt2, fail_cnt2;
    logic [3:0] fail_mask2;
    int         gmode2;

    // SETTLE=1 instance with a NOR model
    logic       rst1, start1, gate_y1;
    logic       drv_a1, drv_b1, busy1, done1, all_pass1;
    logic [2:0] pass_cnt1, fail_cnt1;
    logic [3:0] fail_mask1;

    gate_truth_checker #(.TRUTH(4'b0001), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .gate_y(gate_y2),
        .drv_a(drv_a2), .drv_b(drv_b2), .busy(busy2), .done(done2),
        .all_pass(all_pass2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2),
        .fail_mask(fail_mask2)
    );

    gate_truth_checker #(.TRUTH(4'b0001), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .gate_y(gate_y1),
        .drv_a(drv_a1), .drv_b(drv_b1), .busy(busy1), .done(done1),
        .all_pass(all_pass1), .pass_cnt(pass_cnt1), .fail_cnt(fail_cnt1),
        .fail_mask(fail_mask1)
    );

    always_comb begin
        case (gmode2)
            0:       gate_y2 = ~(drv_a2 | drv_b2);
            1:       gate_y2 = drv_a2 | drv_b2;
            default: gate_y2 = 1'b0;
        endcase
    end
    assign gate_y1 = ~(drv_a1 | drv_b1);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        string    name;
        int       mode;
        int       exp_pass;
        int       exp_fail;
        int       exp_all;
        int       exp_mask;
    } vec_t;

    // one run on dut2; optional start re-pulse during cycles 3-4
    task automatic run2(input int mode, input int restart,
                        output int first_done, output int n_done,
                        output int seq, output int busy_bad);
        logic [15:0] s;
        gmode2 = mode;
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        first_done = -1;
        n_done     = 0;
        s          = 16'h0;
        busy_bad   = 0;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            if (done2) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            if (c < 8) s = {s[13:0], drv_a2, drv_b2};
            if (busy2 != (c < 8)) busy_bad++;
            if (c >= 8 && (drv_a2 || drv_b2)) busy_bad++;
            if (restart != 0 && c == 2) start2 = 1'b1;
            if (restart != 0 && c == 4) start2 = 1'b0;
        end
        seq = int'(s);
    endtask

    vec_t tbl[3];
    int   fd, nd, sq, bb;
    int   dcyc[$];

    initial begin
        tbl[0] = '{"nor",   0, 4, 0, 1, 4'b0000};
        tbl[1] = '{"or",    1, 0, 4, 0, 4'b1111};
        tbl[2] = '{"stuck", 2, 3, 1, 0, 4'b0001};

        gmode2 = 0;
        rst2 = 1'b1; start2 = 1'b0;
        rst1 = 1'b1; start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy",  int'(busy2), 0);
        chk("rst_done",  int'(done2), 0);
        chk("rst_drv",   int'({drv_a2, drv_b2}), 0);
        chk("rst_allp",  int'(all_pass2), 0);
        chk("rst_pass",  int'(pass_cnt2), 0);
        chk("rst_fail",  int'(fail_cnt2), 0);
        chk("rst_mask",  int'(fail_mask2), 0);
        rst2 = 1'b0;
        rst1 = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            run2(tbl[i].mode, 0, fd, nd, sq, bb);
            chk({tbl[i].name, "_done_cyc"}, fd, 8);
            chk({tbl[i].name, "_done_n"},   nd, 1);
            chk({tbl[i].name, "_drv_seq"},  sq, 16'b00_00_01_01_10_10_11_11);
            chk({tbl[i].name, "_busy_drv"}, bb, 0);
            chk({tbl[i].name, "_pass"},     int'(pass_cnt2), tbl[i].exp_pass);
            chk({tbl[i].name, "_fail"},     int'(fail_cnt2), tbl[i].exp_fail);
            chk({tbl[i].name, "_allp"},     int'(all_pass2), tbl[i].exp_all);
            chk({tbl[i].name, "_mask"},     int'(fail_mask2), MASK_ON ? tbl[i].exp_mask : 0);
        end

        // start re-asserted mid-run must be ignored
        run2(0, 1, fd, nd, sq, bb);
        chk("restart_done_cyc", fd, 8);
        chk("restart_done_n",   nd, 1);
        chk("restart_busy_drv", bb, 0);
        chk("restart_pass",     int'(pass_cnt2), 4);
        chk("restart_fail",     int'(fail_cnt2), 0);
        chk("restart_allp",     int'(all_pass2), 1);

        // reset in IDLE clears held results
        rst2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_rst_allp", int'(all_pass2), 0);
        chk("idle_rst_pass", int'(pass_cnt2), 0);
        rst2 = 1'b0;

        // reset at cycle 5 of a stuck-at run aborts it
        gmode2 = 2;
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        nd = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            if (done2) nd++;
        end
        rst2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", int'(busy2), 0);
        chk("abort_done", int'(done2), 0);
        chk("abort_drv",  int'({drv_a2, drv_b2}), 0);
        chk("abort_pass", int'(pass_cnt2), 0);
        chk("abort_fail", int'(fail_cnt2), 0);
        chk("abort_mask", int'(fail_mask2), 0);
        rst2 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done2 || busy2) nd++;
        end
        chk("abort_no_done", nd, 0);
        run2(0, 0, fd, nd, sq, bb);
        chk("post_abort_done_cyc", fd, 8);
        chk("post_abort_pass",     int'(pass_cnt2), 4);
        chk("post_abort_fail",     int'(fail_cnt2), 0);

        // SETTLE=1 with start held high: back-to-back runs
        start1 = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 18; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            if (done1) dcyc.push_back(c);
            if (c == 4)  chk("s1_pass_run1", int'(pass_cnt1), 4);
            if (c == 6)  chk("s1_clear_run2", int'(pass_cnt1), 0);
            if (c == 10) chk("s1_pass_run2", int'(pass_cnt1), 4);
            if (c == 12) chk("s1_clear_run3", int'(pass_cnt1), 0);
        end
        start1 = 1'b0;
        chk("s1_done_n", dcyc.size(), 3);
        if (dcyc.size() == 3) begin
            chk("s1_done0", dcyc[0], 4);
            chk("s1_done1", dcyc[1], 10);
            chk("s1_done2", dcyc[2], 16);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
